// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package addsub_pkg;

  // Width of the arithmetic slice that the sequencer reuses every cycle.
  localparam int NIBBLE_W = 4;

  // Sequencer states: waiting for work, stepping nibbles, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of nibble steps needed to cover an operand of the given width.
  function automatic int nibblesOf(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_nibble_addsub.sv
// One 4-bit add/subtract slice. The b operand is conditionally inverted so
// that subtraction becomes a + ~b + cin. The inverted value is exported
// because the signed-overflow check needs its sign bit.
module nibble_addsub
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_sub,
  input  logic                i_cin,
  output logic [NIBBLE_W-1:0] o_sum,
  output logic [NIBBLE_W-1:0] o_w,
  output logic                o_cout
);

  logic [NIBBLE_W:0] w_total;

  assign o_w     = i_b ^ {NIBBLE_W{i_sub}};
  assign w_total = {1'b0, i_a} + {1'b0, o_w} + {{NIBBLE_W{1'b0}}, i_cin};
  assign o_sum   = w_total[NIBBLE_W-1:0];
  assign o_cout  = w_total[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial add/subtract sequencer. Accepts one WIDTH-bit operation,
// runs it LSB nibble first through a single 4-bit slice while carrying
// between nibbles in a flop, and presents result, carry and signed
// overflow until the consumer takes them.
module nibble_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int NIBBLES = nibblesOf(WIDTH);
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_aLat;
  logic [WIDTH-1:0]   r_bLat;
  logic               r_subLat;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [WIDTH-1:0]   r_result;
  logic               r_carryOut;
  logic               r_overflow;

  logic [NIBBLE_W-1:0] w_aNib;
  logic [NIBBLE_W-1:0] w_bNib;
  logic [NIBBLE_W-1:0] w_sum;
  logic [NIBBLE_W-1:0] w_bx;
  logic                w_cout;

  assign w_aNib = r_aLat[{r_idx, 2'b00} +: NIBBLE_W];
  assign w_bNib = r_bLat[{r_idx, 2'b00} +: NIBBLE_W];

  nibble_addsub u_slice (
    .i_a    (w_aNib),
    .i_b    (w_bNib),
    .i_sub  (r_subLat),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_w    (w_bx),
    .o_cout (w_cout)
  );

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign result    = r_result;
  assign carry_out = r_carryOut;
  assign overflow  = r_overflow;

  // Sequencer: accept, step one nibble per clock, then hold until retired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_aLat     <= '0;
      r_bLat     <= '0;
      r_subLat   <= 1'b0;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_result   <= '0;
      r_carryOut <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_aLat     <= a;
            r_bLat     <= b;
            r_subLat   <= sub;
            r_carry    <= sub;
            r_idx      <= '0;
            r_result   <= '0;
            r_carryOut <= 1'b0;
            r_overflow <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_result[{r_idx, 2'b00} +: NIBBLE_W] <= w_sum;
          r_carry <= w_cout;
          if (r_idx == LAST_IDX) begin
            r_carryOut <= w_cout;
            r_overflow <= (r_aLat[WIDTH-1] == w_bx[NIBBLE_W-1]) &&
                          (w_sum[NIBBLE_W-1] != r_aLat[WIDTH-1]);
            r_idx      <= '0;
            r_state    <= DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed testbench for the nibble-serial add/subtract sequencer.
module tb_nibble_serial_addsub;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] expResult;
    logic             expCarry;
    logic             expOvf;
  } vec_t;

  vec_t vecs[6];
  vec_t b2b[3];

  nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Run one operation end to end: offer it, measure latency, check, retire.
  task automatic applyStimulus(input vec_t v);
    int n;
    int lat;
    in_valid = 1'b1;
    a        = v.a;
    b        = v.b;
    sub      = v.sub;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({v.name, "_accept_wait"}, 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({v.name, "_latency"}, 32'(lat), 32'd4);
    checkOutput({v.name, "_result"}, 32'(result), 32'(v.expResult));
    checkOutput({v.name, "_carry"}, 32'(carry_out), 32'(v.expCarry));
    checkOutput({v.name, "_ovf"}, 32'(overflow), 32'(v.expOvf));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({v.name, "_retired_valid"}, 32'(out_valid), 32'd0);
    checkOutput({v.name, "_retired_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int  n;
    bit  sawValid;
    bit  wasAccept;
    int  acc;
    int  ret;
    int  acceptCyc[3];

    vecs[0] = '{"add_basic",  16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{"sub_nobor",  16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[2] = '{"sub_borrow", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{"add_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{"add_wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{"sub_ovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};

    b2b[0] = '{"b2b_0", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0};
    b2b[1] = '{"b2b_1", 16'hABCD, 16'h1234, 1'b1, 16'h9999, 1'b1, 1'b0};
    b2b[2] = '{"b2b_2", 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    #1 rst = 1'b1;
    #2;
    checkOutput("rst_in_ready",  32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy",      32'(busy), 32'd0);
    checkOutput("rst_result",    32'(result), 32'd0);
    checkOutput("rst_carry",     32'(carry_out), 32'd0);
    checkOutput("rst_ovf",       32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
    end

    // Backpressure: result held while out_ready is low, new request ignored.
    in_valid = 1'b1; a = 16'h0005; b = 16'h0003; sub = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("bp_latency", 32'(n), 32'd4);
    in_valid = 1'b1; a = 16'h0100; b = 16'h0200; sub = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready",  32'(in_ready), 32'd0);
      checkOutput("bp_result",    32'(result), 32'h0002);
      checkOutput("bp_carry",     32'(carry_out), 32'd1);
      checkOutput("bp_ovf",       32'(overflow), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp_idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("bp_queued_accept", 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("bp2_latency", 32'(n), 32'd4);
    checkOutput("bp2_result",  32'(result), 32'h0300);
    checkOutput("bp2_carry",   32'(carry_out), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of nibble 2 discards the operation.
    in_valid = 1'b1; a = 16'h1234; b = 16'h1111; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready",  32'(in_ready), 32'd1);
    checkOutput("midrst_result",    32'(result), 32'd0);
    checkOutput("midrst_busy",      32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sawValid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("midrst_no_result", 32'(sawValid), 32'd0);
    applyStimulus('{"post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0});

    // Back-to-back: in_valid held high, consumer always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = b2b[0].a; b = b2b[0].b; sub = b2b[0].sub;
    acc = 0;
    ret = 0;
    acceptCyc = '{0, 0, 0};
    for (int c = 1; c <= 60 && ret < 3; c++) begin
      wasAccept = in_valid && in_ready;
      @(posedge clk); #1;
      if (wasAccept) begin
        acceptCyc[acc] = c;
        acc++;
        if (acc < 3) begin
          a = b2b[acc].a; b = b2b[acc].b; sub = b2b[acc].sub;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid && ret < 3) begin
        checkOutput({b2b[ret].name, "_result"}, 32'(result), 32'(b2b[ret].expResult));
        checkOutput({b2b[ret].name, "_carry"},  32'(carry_out), 32'(b2b[ret].expCarry));
        checkOutput({b2b[ret].name, "_ovf"},    32'(overflow), 32'(b2b[ret].expOvf));
        ret++;
      end
    end
    out_ready = 1'b0;
    checkOutput("b2b_retired",  32'(ret), 32'd3);
    checkOutput("b2b_accepted", 32'(acc), 32'd3);
    checkOutput("b2b_gap01", 32'(acceptCyc[1] - acceptCyc[0]), 32'd6);
    checkOutput("b2b_gap12", 32'(acceptCyc[2] - acceptCyc[1]), 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Sequencer that feeds our 4-bit add/subtract datapath: it accepts one WIDTH-bit add or subtract operation over a valid/ready handshake.
- It splits the operation into 4-bit nibbles, LSB first, and runs one nibble per clock through a 4-bit add/sub slice.
- It holds the inter-nibble carry in a flop and returns the full result with a carry flag and a signed-overflow flag over a second valid/ready handshake.
- It lets wide arithmetic reuse the 4-bit slice instead of instantiating a WIDTH-bit adder.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived local constant; not overridable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  minuend / addend.
- b  input  WIDTH  subtrahend / addend.
- sub  input  1  0 = a+b, 1 = a-b.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- carry_out  output  1  carry from the MSB nibble; when sub=1, 1 means no borrow (a >= b unsigned).
- overflow  output  1  two's-complement overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: on rst high, immediately and asynchronously go to IDLE.
  - in_ready=1 (combinational from state), out_valid=0, busy=0.
  - result=0, carry_out=0, overflow=0.
  - Nibble index=0, carry flop=0.
  - An operation in flight when rst asserts is discarded; no output is produced for it.
- IDLE: in_ready=1.
  - When in_valid && in_ready at an edge: latch a, b and sub; carry flop <= sub; index <= 0; next state RUN.
  - Clear result, carry_out and overflow at acceptance.
- RUN: in_ready=0, busy=1.
  - Per cycle, with i = index:
    - w = b[4i+3:4i] XOR {4{sub_l}}
    - {c,s} = a_l[4i+3:4i] + w + carry (5-bit result)
    - result[4i+3:4i] <= s; carry <= c; index <= i+1
  - On i = NIBBLES-1:
    - carry_out <= c
    - overflow <= (a_l[WIDTH-1] == w[3]) && (s[3] != a_l[WIDTH-1])
    - next state DONE
  - Index wraps to 0 on the transition to DONE.
- DONE: out_valid=1, busy=1.
  - result, carry_out and overflow are held stable while out_valid && !out_ready (unlimited backpressure).
  - On out_valid && out_ready: next state IDLE, out_valid=0 from the next cycle.
  - Outputs keep their last values in IDLE until the next acceptance.
- Latency and throughput:
  - out_valid rises exactly NIBBLES cycles after the acceptance edge (4 for WIDTH=16).
  - Minimum period between acceptances is NIBBLES+2 cycles.
  - in_ready is never asserted in the same cycle as out_valid, so there is no same-cycle accept/retire.
- Handshake rules:
  - in_valid and operands while busy are ignored and not queued.
  - The upstream must hold a, b, sub and in_valid until in_ready is seen.
  - Operands are sampled only at the acceptance edge; later changes have no effect.
- Arithmetic: result is unsigned modulo 2^WIDTH. Subtraction is a + ~b + 1, with the +1 supplied by the initial carry=sub.

Decomposition:
- Shared package addsub_pkg:
  - state enum {IDLE, RUN, DONE}
  - NIBBLE_W=4 constant
  - function computing NIBBLES from WIDTH
- One sub-module is natural: nibble_addsub (4-bit a, 4-bit b, sub, cin -> 4-bit s, cout, plus b-xor value w for the overflow check).
- The FSM, operand registers, index counter and carry flop stay in the top.

Test Plan:
- Add, WIDTH=16: a=0x1234, b=0x0FFF, sub=0 -> result=0x2233, carry_out=0, overflow=0; out_valid exactly 4 cycles after accept.
- Subtract, no borrow: 0x0005-0x0003 -> 0x0002, carry_out=1, overflow=0. Subtract, borrow: 0x0003-0x0005 -> 0xFFFE, carry_out=0, overflow=0.
- Overflow and wrap-around:
  - 0x7FFF+0x0001 -> 0x8000, overflow=1, carry_out=0.
  - 0xFFFF+0x0001 -> 0x0000, carry_out=1, overflow=0.
  - 0x8000-0x0001 -> 0x7FFF, overflow=1, carry_out=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result, carry_out, overflow and out_valid stable, in_ready=0; a second in_valid with new operands is ignored; after out_ready=1, in_ready=1 next cycle and the queued request is accepted then.
- Reset mid-operation: assert rst during nibble 2 of 0x1234+0x1111 -> immediately out_valid=0, in_ready=1, result=0; no result is ever produced. A following 0x0001+0x0001 gives 0x0002.
- Back-to-back: in_valid held high, out_ready=1, 3 operations -> acceptances spaced exactly 6 cycles apart, each result correct.
